// File: rtl/arbitro_cdb_pkg.sv
// Shared Tomasulo definitions: bus geometry, the reserved "no producer" tag
// and the CDB arbiter state encoding.
package pacote_tomasulo;

    localparam int NUM_UF    = 3;
    localparam int DATA_W    = 16;
    localparam int TAG_W     = 4;
    localparam int TAG_VAZIO = 0;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        DIFUNDINDO = 2'd1,
        PARADO     = 2'd2
    } estado_t;

endpackage

// File: rtl/arbitro_cdb_seletor.sv
// Round-robin selector: first requester at or above Ptr wins, otherwise the
// lowest requester below Ptr (wrap-around). Output is one-hot or zero.
module seletor_round_robin #(
    parameter int NUM_UF = 3,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_UF-1:0] Req,
    input  logic [PTR_W-1:0]  Ptr,
    output logic [NUM_UF-1:0] Gnt
);

    logic [NUM_UF-1:0] mascara;
    logic [NUM_UF-1:0] req_alto;
    logic              achou;

    always_comb begin
        mascara = '0;
        for (int i = 0; i < NUM_UF; i++) begin
            mascara[i] = (i >= int'(Ptr));
        end
    end

    assign req_alto = Req & mascara;

    always_comb begin
        Gnt   = '0;
        achou = 1'b0;
        for (int i = 0; i < NUM_UF; i++) begin
            if (!achou && req_alto[i]) begin
                Gnt[i] = 1'b1;
                achou  = 1'b1;
            end
        end
        // Nothing at or above Ptr: wrap to the lowest requester.
        for (int i = 0; i < NUM_UF; i++) begin
            if (!achou && Req[i]) begin
                Gnt[i] = 1'b1;
                achou  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_cdb.sv
// Common Data Bus arbiter: round-robin grant among functional units, one
// registered broadcast per cycle, held while consumers stall.
//
// Handshake: a unit holds Req/Tag_in/Data_in until it sees Gnt; Gnt is a
// one-cycle accept and the result appears on the CDB at the following edge.
module arbitro_cdb
    import pacote_tomasulo::estado_t;
    import pacote_tomasulo::OCIOSO;
    import pacote_tomasulo::DIFUNDINDO;
    import pacote_tomasulo::PARADO;
#(
    parameter int NUM_UF = pacote_tomasulo::NUM_UF,
    parameter int DATA_W = pacote_tomasulo::DATA_W,
    parameter int TAG_W  = pacote_tomasulo::TAG_W
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Clear,
    input  logic                     Stall,
    input  logic [NUM_UF-1:0]        Req,
    input  logic [NUM_UF*TAG_W-1:0]  Tag_in,
    input  logic [NUM_UF*DATA_W-1:0] Data_in,
    output logic [NUM_UF-1:0]        Gnt,
    output logic                     CDB_Valid,
    output logic [TAG_W-1:0]         CDB_Tag,
    output logic [DATA_W-1:0]        CDB_Data,
    output logic [1:0]               CDB_Src,
    output estado_t                  Estado
);

    localparam int PTR_W = (NUM_UF > 1) ? $clog2(NUM_UF) : 1;

    estado_t           estado, estado_prox;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic [NUM_UF-1:0] gnt_sel;
    logic [TAG_W-1:0]  tag_sel;
    logic [DATA_W-1:0] data_sel;
    logic              stall_ativo;
    logic              concede;
    logic              difunde;

    seletor_round_robin #(
        .NUM_UF (NUM_UF),
        .PTR_W  (PTR_W)
    ) u_seletor (
        .Req (Req),
        .Ptr (ptr),
        .Gnt (gnt_sel)
    );

    // Stall only blocks while something is actually on the bus.
    assign stall_ativo = Stall && (estado != OCIOSO);
    assign concede     = !Reset && !Clear && !stall_ativo;
    assign Gnt         = concede ? gnt_sel : '0;

    always_comb begin
        gnt_idx  = '0;
        tag_sel  = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_UF; i++) begin
            if (Gnt[i]) begin
                gnt_idx  = PTR_W'(i);
                tag_sel  = Tag_in[i*TAG_W +: TAG_W];
                data_sel = Data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // A tag-0 result is accepted (Gnt) but never reaches the bus.
    assign difunde = (|Gnt) && (tag_sel != TAG_W'(pacote_tomasulo::TAG_VAZIO));

    always_comb begin
        estado_prox = estado;
        if (Clear) begin
            estado_prox = OCIOSO;
        end else begin
            case (estado)
                OCIOSO: begin
                    estado_prox = difunde ? DIFUNDINDO : OCIOSO;
                end
                DIFUNDINDO, PARADO: begin
                    if (Stall)        estado_prox = PARADO;
                    else if (difunde) estado_prox = DIFUNDINDO;
                    else              estado_prox = OCIOSO;
                end
                default: estado_prox = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado   <= OCIOSO;
            ptr      <= '0;
            CDB_Tag  <= '0;
            CDB_Data <= '0;
            CDB_Src  <= '0;
        end else begin
            estado <= estado_prox;
            if (|Gnt) begin
                ptr <= (gnt_idx == PTR_W'(NUM_UF - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (difunde) begin
                CDB_Tag  <= tag_sel;
                CDB_Data <= data_sel;
                CDB_Src  <= 2'(gnt_idx);
            end
        end
    end

    assign CDB_Valid = (estado != OCIOSO);
    assign Estado    = estado;

endmodule

// File: tb/tb_arbitro_cdb.sv
// Directed bench for arbitro_cdb: expected broadcasts are queued when a grant
// is expected and compared when the CDB presents them.
module tb_arbitro_cdb;
    import pacote_tomasulo::*;

    logic        Clock;
    logic        Reset;
    logic        Clear;
    logic        Stall;
    logic [2:0]  Req;
    logic [11:0] Tag_in;
    logic [47:0] Data_in;
    logic [2:0]  Gnt;
    logic        CDB_Valid;
    logic [3:0]  CDB_Tag;
    logic [15:0] CDB_Data;
    logic [1:0]  CDB_Src;
    estado_t     Estado;

    int errors = 0;
    int checks = 0;

    logic [21:0] exp_q[$];
    logic [3:0]  tg[3];
    logic [15:0] dt[3];
    logic [3:0]  last_tag;
    logic [15:0] last_data;
    logic [1:0]  last_src;

    arbitro_cdb dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Clear     (Clear),
        .Stall     (Stall),
        .Req       (Req),
        .Tag_in    (Tag_in),
        .Data_in   (Data_in),
        .Gnt       (Gnt),
        .CDB_Valid (CDB_Valid),
        .CDB_Tag   (CDB_Tag),
        .CDB_Data  (CDB_Data),
        .CDB_Src   (CDB_Src),
        .Estado    (Estado)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    task automatic set_uf(input int i, input logic [3:0] tag, input logic [15:0] data);
        tg[i] = tag;
        dt[i] = data;
        Tag_in[i*4 +: 4]    = tag;
        Data_in[i*16 +: 16] = data;
    endtask

    // Drive one cycle's inputs, check Gnt before the edge, then check the CDB after it.
    task automatic cycle(input logic [2:0] req, input logic stall, input logic clear,
                         input logic [2:0] exp_gnt, input logic exp_valid, input string name);
        logic        pushed;
        logic [21:0] e;
        int          idx;
        pushed = 1'b0;
        Req   = req;
        Stall = stall;
        Clear = clear;
        #1;
        chk({name, ".gnt"}, 32'(Gnt), 32'(exp_gnt));
        if (exp_gnt != 3'b000) begin
            idx = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
            if (tg[idx] != 4'd0) begin
                exp_q.push_back({2'(idx), tg[idx], dt[idx]});
                pushed = 1'b1;
            end
        end
        @(posedge Clock);
        #1;
        chk({name, ".valid"}, 32'(CDB_Valid), 32'(exp_valid));
        if (pushed) begin
            e = exp_q.pop_front();
            {last_src, last_tag, last_data} = e;
            chk({name, ".src"},  32'(CDB_Src),  32'(last_src));
            chk({name, ".tag"},  32'(CDB_Tag),  32'(last_tag));
            chk({name, ".data"}, 32'(CDB_Data), 32'(last_data));
        end else if (exp_valid) begin
            chk({name, ".hold_tag"},  32'(CDB_Tag),  32'(last_tag));
            chk({name, ".hold_data"}, 32'(CDB_Data), 32'(last_data));
        end
    endtask

    task automatic reset_pulse(input logic [2:0] req, input string name);
        Reset = 1'b1;
        Req   = req;
        #1;
        chk({name, ".gnt"}, 32'(Gnt), 32'd0);
        @(posedge Clock);
        #1;
        chk({name, ".valid"}, 32'(CDB_Valid), 32'd0);
        chk({name, ".tag"},   32'(CDB_Tag),   32'd0);
        chk({name, ".data"},  32'(CDB_Data),  32'd0);
        chk({name, ".src"},   32'(CDB_Src),   32'd0);
        chk({name, ".state"}, 32'(Estado),    32'(OCIOSO));
        Reset = 1'b0;
        Req   = 3'b000;
    endtask

    initial begin
        Reset = 1'b1; Clear = 1'b0; Stall = 1'b0; Req = 3'b000;
        Tag_in = '0; Data_in = '0;
        for (int i = 0; i < 3; i++) begin tg[i] = '0; dt[i] = '0; end
        last_tag = '0; last_data = '0; last_src = '0;
        repeat (2) @(posedge Clock);
        #1;
        set_uf(0, 4'd1, 16'h1111);
        set_uf(1, 4'd2, 16'h2222);
        set_uf(2, 4'd3, 16'h3333);
        reset_pulse(3'b111, "reset");

        // Single grant, one-cycle latency
        set_uf(0, 4'd3, 16'h00AA);
        cycle(3'b001, 0, 0, 3'b001, 1, "single");
        cycle(3'b000, 0, 0, 3'b000, 0, "idle1");
        set_uf(2, 4'd7, 16'h0777);
        cycle(3'b100, 0, 0, 3'b100, 1, "wrap_to0");
        cycle(3'b000, 0, 0, 3'b000, 0, "idle2");

        // All three request together, Ptr=0
        set_uf(0, 4'd1, 16'h1111);
        set_uf(1, 4'd2, 16'h2222);
        set_uf(2, 4'd3, 16'h3333);
        cycle(3'b111, 0, 0, 3'b001, 1, "rr0");
        cycle(3'b110, 0, 0, 3'b010, 1, "rr1");
        cycle(3'b100, 0, 0, 3'b100, 1, "rr2");
        cycle(3'b000, 0, 0, 3'b000, 0, "rr_idle");

        // Stall holds tag 5 for three cycles, unit 1 granted when Stall drops
        set_uf(0, 4'd5, 16'h0555);
        cycle(3'b001, 0, 0, 3'b001, 1, "st_bcast");
        set_uf(1, 4'd9, 16'h0999);
        cycle(3'b010, 1, 0, 3'b000, 1, "stall1");
        chk("stall1.state", 32'(Estado), 32'(PARADO));
        cycle(3'b010, 1, 0, 3'b000, 1, "stall2");
        cycle(3'b010, 0, 0, 3'b010, 1, "st_release");
        cycle(3'b000, 0, 0, 3'b000, 0, "st_idle");

        // Tag 0 is granted but not broadcast, Ptr still advances to 0
        set_uf(2, 4'd0, 16'h0ABC);
        cycle(3'b100, 0, 0, 3'b100, 0, "tag0");
        set_uf(0, 4'd4, 16'h0444);
        set_uf(1, 4'd6, 16'h0666);
        cycle(3'b011, 0, 0, 3'b001, 1, "after_tag0");
        cycle(3'b010, 0, 0, 3'b010, 1, "after_tag0b");
        cycle(3'b000, 0, 0, 3'b000, 0, "t0_idle");

        // Clear with Stall while held; Ptr left at 0
        set_uf(2, 4'hA, 16'h0AAA);
        cycle(3'b100, 0, 0, 3'b100, 1, "cl_bcast");
        cycle(3'b000, 1, 0, 3'b000, 1, "cl_park");
        chk("cl_park.state", 32'(Estado), 32'(PARADO));
        cycle(3'b001, 1, 1, 3'b000, 0, "clear_stall");
        cycle(3'b010, 0, 1, 3'b000, 0, "clear_idle");
        set_uf(0, 4'hB, 16'h0BBB);
        cycle(3'b011, 0, 0, 3'b001, 1, "after_clear");

        // Reset mid-broadcast, grant restarts from unit 0
        reset_pulse(3'b010, "mid_reset");
        set_uf(0, 4'hC, 16'h0CCC);
        set_uf(1, 4'hD, 16'h0DDD);
        cycle(3'b011, 0, 0, 3'b001, 1, "post_rst0");
        cycle(3'b010, 0, 0, 3'b010, 1, "post_rst1");
        cycle(3'b000, 0, 0, 3'b000, 0, "post_idle");

        // Stall while idle does not block
        set_uf(2, 4'hE, 16'h0EEE);
        cycle(3'b100, 1, 0, 3'b100, 1, "idle_stall");
        cycle(3'b000, 0, 0, 3'b000, 0, "final_idle");

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbitro_cdb.md
ARBITRO_CDB -- requirements
Module: arbitro_cdb

Interface
REQ-001 Parameter NUM_UF, default 3: number of functional units sharing the Common Data Bus (CDB).
REQ-002 Parameter DATA_W, default 16: width of the result data.
REQ-003 Parameter TAG_W, default 4: width of the reservation-station tag; tag 0 is reserved to mean "no producer".
REQ-004 Port Clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1: synchronous, active-high reset.
REQ-006 Port Clear, input, 1: flush (mispredict or restart); cancels the broadcast in flight.
REQ-007 Port Stall, input, 1: CDB consumers not accepting this cycle.
REQ-008 Port Req, input, NUM_UF: per-unit request to broadcast (each unit's Write_Enable_CDB).
REQ-009 Port Tag_in, input, NUM_UF*TAG_W: per-unit result tag; unit i occupies bits [i*TAG_W +: TAG_W].
REQ-010 Port Data_in, input, NUM_UF*DATA_W: per-unit result data, packed in the same way as Tag_in.
REQ-011 Port Gnt, output, NUM_UF: one-hot grant; unit i's result is captured at this edge.
REQ-012 Port CDB_Valid, output, 1: a broadcast is present on the CDB.
REQ-013 Port CDB_Tag, output, TAG_W: tag being broadcast.
REQ-014 Port CDB_Data, output, DATA_W: data being broadcast.
REQ-015 Port CDB_Src, output, 2: index of the unit that produced the current broadcast.

Function
REQ-016 Gnt shall be combinational from Req, Ptr, state, Stall and Clear, with at most one bit set.
REQ-017 Round-robin search order shall be Ptr, Ptr+1, ... modulo NUM_UF (wrap-around); after a grant to unit i, Ptr shall become (i+1) mod NUM_UF.
REQ-018 On a grant, Tag_in, Data_in and source index shall be registered into CDB_Tag, CDB_Data and CDB_Src, and CDB_Valid shall be set on the next cycle: latency is 1 cycle from granted Req to CDB_Valid.
REQ-019 A unit shall hold Req, Tag_in and Data_in stable until it sees Gnt; Gnt lasts exactly one cycle per accepted result.
REQ-020 States: OCIOSO (CDB_Valid=0), DIFUNDINDO (CDB_Valid=1, first cycle), PARADO (CDB_Valid=1, held by Stall).
REQ-021 Transitions in OCIOSO:
- grant present -> DIFUNDINDO
- no grant -> stay in OCIOSO
REQ-022 Transitions in DIFUNDINDO or PARADO:
- Stall=1 -> PARADO
- Stall=0 and grant -> DIFUNDINDO (back-to-back broadcasts, one per cycle)
- Stall=0 and no grant -> OCIOSO
REQ-023 While Stall=1 and CDB_Valid=1: Gnt=0, and CDB outputs and Ptr are held.
REQ-024 Stall=1 while in OCIOSO shall not block granting.
REQ-025 A granted request carrying tag 0 shall receive Gnt but shall not be broadcast: it counts as no grant for state and CDB_Valid, and Ptr still advances.
REQ-026 Clear=1 shall force Gnt=0, set CDB_Valid to 0 next cycle, move to OCIOSO and leave Ptr unchanged.
REQ-027 Clear shall take priority over Stall and over any request.
REQ-028 Simultaneous Req from all units shall be served in round-robin order, so each unit waits at most NUM_UF-1 grants.

Reset
REQ-029 On Reset=1 at a clock edge: state OCIOSO, Ptr=0, CDB_Valid=0, CDB_Tag=0, CDB_Data=0, CDB_Src=0; Gnt=0 while Reset is high.
REQ-030 Reset shall take priority over Clear, Stall and Req, including mid-broadcast and mid-stall.

Structure
REQ-031 Shared package pacote_tomasulo shall hold NUM_UF, DATA_W, TAG_W, the reserved tag TAG_VAZIO=0 and the state encoding.
REQ-032 The round-robin pointer search shall be one sub-module, seletor_round_robin (Req and Ptr in, one-hot grant out).

Verification
REQ-033 After reset, set Req=001 with tag 3 and data 0x00AA -> Gnt=001 that cycle; next cycle CDB_Valid=1, CDB_Tag=3, CDB_Data=0x00AA, CDB_Src=0.
REQ-034 Hold Req=111 (tags 1, 2, 3) for 3 cycles with Ptr=0 -> grants 001, 010, 100 on consecutive cycles, each unit dropping its request after its grant; broadcasts of tags 1, 2, 3 back-to-back; Ptr wraps to 0.
REQ-035 During the broadcast of tag 5, raise Stall for 2 cycles with Req=010 pending -> CDB holds tag 5 for 3 cycles total with Gnt=0; unit 1 is granted on the cycle Stall drops.
REQ-036 Req=100 with tag 0 -> Gnt=100 and CDB_Valid stays 0; a following Req=001 is granted (Ptr=0).
REQ-037 Raise Clear and Stall together while in PARADO -> CDB_Valid=0 next cycle and Gnt=0 that cycle.
REQ-038 Assert Reset during a broadcast -> all outputs are 0 at the next edge, and the next grant starts from unit 0.
